lms: RTL and testbench

Adaptive FIR filter using the least-mean-squares algorithm. It processes one 16-bit sample per clock and has two modes. In adaptive line-enhancer mode it predicts the periodic part of `dataIn` from its own delayed history. In noise-canceller mode it subtracts an adapted copy of an external noise reference `refIn`. It sits in the sample-rate datapath between the ADC-side sample source and downstream processing.

---
 rtl/lms_pkg.sv | 38 +++
 rtl/lms_tap.sv | 47 ++++
 rtl/lms.sv | 83 ++++++++
 tb/tb_lms.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// lms_pkg: shared constants and helpers for the LMS adaptive filter.
//   WGT_W / WGT_FRAC : weight width and fraction bits (signed Q2.30)
//   MU_SHIFT         : step size is STEP / 2^MU_SHIFT
//   ACC_W()          : full-precision width of the tap-product sum
//   sat_to()         : clamp a 64-bit signed value to a w-bit signed range
//   sat_wgt()        : clamp to the weight range
package lms_pkg;

  localparam int WGT_W    = 32;
  localparam int WGT_FRAC = 30;
  localparam int MU_SHIFT = 15;

  // Sum of TAP products of WGT_W x dat_w bits never overflows this width.
  function automatic int ACC_W(input int dat_w, input int tap);
    return WGT_W + dat_w + $clog2(tap);
  endfunction

  // Clamp to [-2^(w-1), 2^(w-1)-1]; the caller narrows the result to w bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

  function automatic logic signed [WGT_W-1:0] sat_wgt(input logic signed [63:0] v);
    return WGT_W'(sat_to(v, WGT_W));
  endfunction

endpackage

// File: rtl/lms_tap.sv
// lms_tap: one delay-line stage of the LMS filter with its adaptive weight.
//   clk   : sample clock
//   rst   : asynchronous active-low reset (clears sample and weight)
//   x_in  : sample entering this stage
//   e     : current (pre-edge) error, shared by all taps
//   x_out : registered sample held by this stage (feeds the next stage)
//   wx    : full-precision product weight * held sample
module lms_tap
  import lms_pkg::*;
#(
  parameter int DAT_W = 16,
  parameter int STEP  = 48
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [DAT_W-1:0]        x_in,
  input  logic signed [DAT_W-1:0]        e,
  output logic signed [DAT_W-1:0]        x_out,
  output logic signed [WGT_W+DAT_W-1:0]  wx
);

  localparam int WX_W = WGT_W + DAT_W;

  logic signed [DAT_W-1:0] r_x;
  logic signed [WGT_W-1:0] r_w;
  logic signed [63:0]      w_grad;
  logic signed [63:0]      w_sum;

  assign x_out = r_x;
  assign wx    = WX_W'(r_w) * WX_W'(r_x);

  // e*x*STEP is at most ~2^31 * STEP, well inside 64 bits; >>> floors.
  assign w_grad = 64'(e) * 64'(r_x) * 64'(STEP);
  assign w_sum  = 64'(r_w) + (w_grad >>> MU_SHIFT);

  // Delay stage and weight update, both using the pre-edge sample and error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x <= '0;
      r_w <= '0;
    end else begin
      r_x <= x_in;
      r_w <= sat_wgt(w_sum);
    end
  end

endmodule

// File: rtl/lms.sv
// lms: adaptive FIR filter trained by the least-mean-squares rule.
//   clk      : sample clock, one sample per rising edge
//   rst      : asynchronous active-low reset
//   dataIn   : desired signal d (signed Q1.15)
//   refIn    : noise reference, filter input when isOutRef = 1
//   isOutRef : 0 = line enhancer (output y), 1 = noise canceller (output e)
//   dataOut  : registered filter result
module lms
  import lms_pkg::*;
#(
  parameter int DAT_W = 16,
  parameter int STEP  = 48,
  parameter int TAP   = 63
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DAT_W-1:0] dataIn,
  input  logic signed [DAT_W-1:0] refIn,
  input  logic                    isOutRef,
  output logic signed [DAT_W-1:0] dataOut
);

  localparam int AW   = ACC_W(DAT_W, TAP);
  localparam int WX_W = WGT_W + DAT_W;

  logic signed [DAT_W-1:0] r_d;
  logic signed [DAT_W-1:0] w_xin;
  logic signed [DAT_W-1:0] w_xd [0:TAP-1];
  logic signed [WX_W-1:0]  w_wx [0:TAP-1];
  logic signed [AW-1:0]    w_acc;
  logic signed [DAT_W-1:0] w_y;
  logic signed [DAT_W-1:0] w_e;

  // In line-enhancer mode the filter sees d one sample late, which is the
  // decorrelation delay that lets it predict only the periodic part.
  assign w_xin = isOutRef ? refIn : r_d;

  genvar gi;
  generate
    for (gi = 0; gi < TAP; gi++) begin : g_tap
      logic signed [DAT_W-1:0] w_tin;
      if (gi == 0) begin : g_head
        assign w_tin = w_xin;
      end else begin : g_link
        assign w_tin = w_xd[gi-1];
      end
      lms_tap #(
        .DAT_W(DAT_W),
        .STEP (STEP)
      ) u_tap (
        .clk  (clk),
        .rst  (rst),
        .x_in (w_tin),
        .e    (w_e),
        .x_out(w_xd[gi]),
        .wx   (w_wx[gi])
      );
    end
  endgenerate

  // Full-precision sum of all tap products; synthesis balances the chain.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < TAP; i++) begin
      w_acc = w_acc + AW'(w_wx[i]);
    end
  end

  assign w_y = DAT_W'(sat_to(64'(w_acc >>> WGT_FRAC), DAT_W));
  assign w_e = DAT_W'(sat_to(64'(r_d) - 64'(w_y), DAT_W));

  // Desired-sample register and output register; both see the pre-edge e/y.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d     <= '0;
      dataOut <= '0;
    end else begin
      r_d     <= dataIn;
      dataOut <= isOutRef ? w_e : w_y;
    end
  end

endmodule

// File: tb/tb_lms.sv
// tb_lms: directed self-checking bench for the lms adaptive filter.
module tb_lms;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] dataIn;
  logic signed [15:0] refIn;
  logic               isOutRef;
  logic signed [15:0] dataOut;

  int n_tests = 0;
  int n_fail  = 0;

  lms #(
    .DAT_W(16),
    .STEP (48),
    .TAP  (63)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dataIn  (dataIn),
    .refIn   (refIn),
    .isOutRef(isOutRef),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with junk inputs, then release with the next test's inputs applied.
  task automatic apply_reset(input int din, input int rin, input logic mode);
    rst      = 1'b0;
    dataIn   = 16'sh1234;
    refIn    = -16'sd777;
    isOutRef = 1'b1;
    step();
    step();
    step();
    dataIn   = 16'(din);
    refIn    = 16'(rin);
    isOutRef = mode;
    rst      = 1'b1;
  endtask

  task automatic test_reset();
    int tbl [6] = '{100, -200, 32767, -32768, 5, 0};
    rst      = 1'b0;
    dataIn   = 16'sd12345;
    refIn    = -16'sd777;
    isOutRef = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (dataOut !== 16'sd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %0d want 0", i, dataOut);
      end
    end
    // Mode 1 with zero reference: weights never move, so dataOut = d delayed.
    refIn = 16'sd0;
    rst   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      dataIn = (i < 6) ? 16'(tbl[i]) : 16'sd0;
      step();
      n_tests++;
      if (dataOut !== ((i == 0) ? 16'sd0 : 16'(tbl[i-1]))) begin
        n_fail++;
        $display("FAIL reset_zero_weights[%0d]: got %0d want %0d", i, dataOut,
                 (i == 0) ? 0 : tbl[i-1]);
      end
    end
  endtask

  task automatic test_passthrough();
    apply_reset(1000, 0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step();
      n_tests++;
      if (dataOut !== ((i == 1) ? 16'sd0 : 16'sd1000)) begin
        n_fail++;
        $display("FAIL passthrough[edge %0d]: got %0d want %0d", i, dataOut,
                 (i == 1) ? 0 : 1000);
      end
    end
  endtask

  // Hand-derived first outputs for a constant 8192 input from zero weights.
  task automatic check_le_start(input string tag);
    int exp_le [6] = '{0, 0, 0, 0, 2, 4};
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++;
      if (dataOut !== 16'(exp_le[i])) begin
        n_fail++;
        $display("FAIL %s[edge %0d]: got %0d want %0d", tag, i + 1, dataOut, exp_le[i]);
      end
    end
  endtask

  task automatic test_line_enhancer();
    int   prev;
    logic mono_ok;
    apply_reset(8192, 0, 1'b0);
    check_le_start("le_start");
    prev    = int'(dataOut);
    mono_ok = 1'b1;
    for (int i = 6; i < 20000; i++) begin
      step();
      if (int'(dataOut) < prev) mono_ok = 1'b0;
      prev = int'(dataOut);
    end
    n_tests++;
    if (mono_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL le_monotonic: got non-monotonic want monotonic rise");
    end
    n_tests++;
    if (int'(dataOut) < 8128 || int'(dataOut) > 8256) begin
      n_fail++;
      $display("FAIL le_settle: got %0d want 8192+-64", dataOut);
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b0;
    #1;
    n_tests++;
    if (dataOut !== 16'sd0) begin
      n_fail++;
      $display("FAIL midrst_async: got %0d want 0", dataOut);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (dataOut !== 16'sd0) begin
        n_fail++;
        $display("FAIL midrst_hold[%0d]: got %0d want 0", i, dataOut);
      end
    end
    rst = 1'b1;
    check_le_start("midrst_restart");
  endtask

  task automatic test_saturation();
    logic nonneg;
    apply_reset(32767, -32768, 1'b1);
    step();
    n_tests++;
    if (dataOut !== 16'sd0) begin
      n_fail++;
      $display("FAIL sat_edge1: got %0d want 0", dataOut);
    end
    step();
    n_tests++;
    if (dataOut !== 16'sd32767) begin
      n_fail++;
      $display("FAIL sat_edge2: got %0d want 32767", dataOut);
    end
    step();
    n_tests++;
    if (dataOut !== 16'sd32720) begin
      n_fail++;
      $display("FAIL sat_edge3: got %0d want 32720", dataOut);
    end
    nonneg = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (dataOut < 16'sd0) nonneg = 1'b0;
    end
    n_tests++;
    if (nonneg !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_no_wrap: got negative output want >= 0");
    end
    n_tests++;
    if (dataOut < 16'sd0 || dataOut > 16'sd2) begin
      n_fail++;
      $display("FAIL sat_converged: got %0d want 0..2", dataOut);
    end
    // y is near full scale, so d = -32768 drives d - y far below range.
    dataIn = -16'sd32768;
    step();
    step();
    n_tests++;
    if (dataOut !== -16'sd32768) begin
      n_fail++;
      $display("FAIL sat_e_clamp: got %0d want -32768", dataOut);
    end
    // Mode change takes effect next edge: output becomes the large positive y.
    isOutRef = 1'b0;
    step();
    n_tests++;
    if (dataOut <= 16'sd16000) begin
      n_fail++;
      $display("FAIL mode_switch_y: got %0d want > 16000", dataOut);
    end
  endtask

  task automatic test_noise_cancel();
    int  s;
    int  h;
    int  s_prev;
    int  h_prev;
    int  err;
    real ms_err;
    real ms_ref;
    apply_reset(0, 0, 1'b1);
    s_prev = 0;
    h_prev = 0;
    ms_err = 0.0;
    ms_ref = 0.0;
    for (int k = 0; k < 32000; k++) begin
      s = int'(8000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 50.0));
      h = int'($urandom_range(16000, 0)) - 8000;  // h = 0.5 * n
      dataIn = 16'(s + h);
      refIn  = 16'(2 * h);
      step();
      // dataOut now carries e for the previous sample.
      if (k > 30000) begin
        err    = int'(dataOut) - s_prev;
        ms_err = ms_err + real'(err) * real'(err);
        ms_ref = ms_ref + real'(h_prev) * real'(h_prev);
      end
      s_prev = s;
      h_prev = h;
    end
    n_tests++;
    if (ms_err >= 0.05 * ms_ref) begin
      n_fail++;
      $display("FAIL noise_cancel: got err energy %0f want < %0f", ms_err, 0.05 * ms_ref);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_line_enhancer();
    test_reset_mid_run();
    test_saturation();
    test_noise_cancel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
